// File: rtl/data_sram_initiator.sv
// data_sram_initiator: in-order master for the req/addr_ok/data_ok data SRAM bus.
// Define DATA_SRAM_INIT_MISALIGN_EN to reject misaligned ops instead of forcing alignment.
module data_sram_initiator #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_wr,
  input  logic [1:0]  op_size,
  input  logic        op_sext,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_tag,
  input  logic        flush,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        res_valid,
  output logic        res_wr,
  output logic [4:0]  res_tag,
  output logic [31:0] res_data,
  output logic        misalign
);
`ifdef DATA_SRAM_INIT_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic       sext;
    logic [1:0] a;
    logic [4:0] tag;
  } ent_t;
  ent_t q [MAX_OUTST];
  ent_t head;
  logic [MAX_OUTST-1:0] cancel;
  logic [PW-1:0] wp, rp;
  logic [CNT_W-1:0] cnt, occ;
  logic held_cancel, held_sext;
  logic [4:0] held_tag;
  logic [1:0] nsize;
  logic [31:0] naddr, wd, sh, ld;
  logic [3:0] strb;
  logic bad, accept, issue, push, pop, v;
  always_comb begin
    nsize = op_size == 2'd3 ? 2'd2 : op_size;
    bad = (nsize == 2'd1 && op_addr[0]) || (nsize == 2'd2 && op_addr[1:0] != 2'd0);
    naddr = {op_addr[31:2], nsize == 2'd2 ? 2'b00 : {op_addr[1], nsize == 2'd1 ? 1'b0 : op_addr[0]}};
    strb = nsize == 2'd0 ? 4'b0001 << naddr[1:0] : nsize == 2'd1 ? (naddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = nsize == 2'd0 ? {4{op_wdata[7:0]}} : nsize == 2'd1 ? {2{op_wdata[15:0]}} : op_wdata;
    occ = cnt + CNT_W'(req);
    op_ready = (!req || addr_ok) && occ < CNT_W'(MAX_OUTST) && !flush;
    accept = op_valid && op_ready;
    issue = accept && !(MIS && bad);
    push = req && addr_ok;
    pop = data_ok && cnt != '0;
    head = q[rp];
    v = pop && !cancel[rp] && !flush;
    sh = rdata >> {head.a, 3'b000};
    ld = head.size == 2'd0 ? {{24{head.sext & sh[7]}}, sh[7:0]} :
         head.size == 2'd1 ? {{16{head.sext & sh[15]}}, sh[15:0]} : rdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req <= 1'b0;
      wr <= 1'b0;
      size <= '0;
      wstrb <= '0;
      addr <= '0;
      wdata <= '0;
      held_cancel <= 1'b0;
      held_sext <= 1'b0;
      held_tag <= '0;
      cancel <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      res_valid <= 1'b0;
      res_wr <= 1'b0;
      res_tag <= '0;
      res_data <= '0;
      misalign <= 1'b0;
    end else begin
      if (issue) begin
        req <= 1'b1;
        wr <= op_wr;
        size <= nsize;
        addr <= naddr;
        wstrb <= op_wr ? strb : 4'b0000;
        wdata <= wd;
        held_sext <= op_sext;
        held_tag <= op_tag;
        held_cancel <= 1'b0;
      end else if (push) req <= 1'b0;
      if (flush) held_cancel <= 1'b1;
      if (flush) cancel <= '1;
      // the held request inherits a flush seen in its own handshake cycle
      if (push) begin
        q[wp] <= {wr, size, held_sext, addr[1:0], held_tag};
        cancel[wp] <= held_cancel || flush;
        wp <= wp == PW'(MAX_OUTST - 1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == PW'(MAX_OUTST - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      res_valid <= v;
      res_wr <= v && head.wr;
      res_tag <= v ? head.tag : '0;
      res_data <= v && !head.wr ? ld : '0;
      misalign <= MIS && accept && bad;
    end
  end
endmodule
